// File: rtl/commit_trace_fifo.sv
// Commit trace FIFO: one record per retired instruction, drained over valid/ready.
// Ports: commit_* retire side in, trace_* sink side out, level and drop_count status.
module commit_trace_fifo #(
  parameter int XLEN          = 32,
  parameter int NREGS         = 16,
  parameter int DEPTH         = 8,
  parameter int SEQW          = 16,
  parameter int CNTW          = 16,
  parameter bit STALL_ON_FULL = 1'b1,
  localparam int AW           = $clog2(NREGS),
  localparam int LW           = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            commit_valid,
  output logic            commit_ready,
  input  logic [XLEN-1:0] commit_pc,
  input  logic [31:0]     commit_instr,
  input  logic            rd_we,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] rd_data,
  output logic            trace_valid,
  input  logic            trace_ready,
  output logic [SEQW-1:0] trace_seq,
  output logic [XLEN-1:0] trace_pc,
  output logic [31:0]     trace_instr,
  output logic            trace_rd_we,
  output logic [AW-1:0]   trace_rd_addr,
  output logic [XLEN-1:0] trace_rd_data,
  output logic [LW-1:0]   level,
  output logic [CNTW-1:0] drop_count
);

  localparam int PW = LW - 1;

  typedef struct packed {
    logic [SEQW-1:0] seq;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            we;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } rec_t;

  rec_t            mem_q [DEPTH];
  rec_t            rec_w;
  rec_t            head_w;

  logic [PW:0]     wr_ptr_q, wr_ptr_d;
  logic [PW:0]     rd_ptr_q, rd_ptr_d;
  logic [SEQW-1:0] seq_q, seq_d;
  logic [CNTW-1:0] drop_q, drop_d;

  logic [LW-1:0]   level_w;
  logic            full_w;
  logic            empty_w;
  logic            push_w;
  logic            pop_w;
  logic            wr_en_w;
  logic            drop_w;

  // Extra wrap bit makes the pointer difference the exact occupancy.
  assign level_w = wr_ptr_q - rd_ptr_q;
  assign full_w  = (level_w == LW'(DEPTH));
  assign empty_w = (level_w == '0);

  // Stall mode looks only at stored occupancy, never at trace_ready.
  assign commit_ready = !rst && (STALL_ON_FULL ? !full_w : 1'b1);

  assign push_w  = commit_valid && commit_ready;
  assign pop_w   = !empty_w && trace_ready;
  assign wr_en_w = push_w && (!full_w || pop_w);
  assign drop_w  = push_w && full_w && !pop_w;

  always_comb begin
    rec_w       = '0;
    rec_w.seq   = seq_q;
    rec_w.pc    = commit_pc;
    rec_w.instr = commit_instr;
    // x0 writes are architecturally invisible; never report them.
    rec_w.we    = rd_we && (rd_addr != '0);
    rec_w.addr  = rd_addr;
    rec_w.data  = rd_data;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    seq_d    = seq_q;
    drop_d   = drop_q;
    if (wr_en_w) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_w)   rd_ptr_d = rd_ptr_q + 1'b1;
    // Dropped commits still consume a number, leaving a visible gap.
    if (push_w)  seq_d    = seq_q + SEQW'(1);
    if (drop_w && (drop_q != '1)) drop_d = drop_q + CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      seq_q    <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      seq_q    <= seq_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_w && !rst) mem_q[wr_ptr_q[PW-1:0]] <= rec_w;
  end

  assign head_w        = mem_q[rd_ptr_q[PW-1:0]];
  assign trace_valid   = !empty_w;
  assign trace_seq     = head_w.seq;
  assign trace_pc      = head_w.pc;
  assign trace_instr   = head_w.instr;
  assign trace_rd_we   = head_w.we;
  assign trace_rd_addr = head_w.addr;
  assign trace_rd_data = head_w.data;
  assign level         = level_w;
  assign drop_count    = drop_q;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Bench for commit_trace_fifo: one stall-mode and one drop-mode instance.
// Expected records queue per instance; negedge monitors pop and compare.
module tb_commit_trace_fifo;

  typedef struct {
    logic [15:0] seq;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] data;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        s_cv, s_cr, s_we, s_tv, s_tr, s_twe;
  logic [31:0] s_pc, s_instr, s_data, s_tpc, s_tinstr, s_tdata;
  logic [3:0]  s_addr, s_taddr, s_level;
  logic [15:0] s_tseq, s_drop;

  logic        d_cv, d_cr, d_we, d_tv, d_tr, d_twe;
  logic [31:0] d_pc, d_instr, d_data, d_tpc, d_tinstr, d_tdata;
  logic [3:0]  d_addr, d_taddr, d_level;
  logic [15:0] d_tseq, d_drop;

  commit_trace_fifo #(.STALL_ON_FULL(1'b1)) u_stall (
    .clk(clk), .rst(rst),
    .commit_valid(s_cv), .commit_ready(s_cr),
    .commit_pc(s_pc), .commit_instr(s_instr),
    .rd_we(s_we), .rd_addr(s_addr), .rd_data(s_data),
    .trace_valid(s_tv), .trace_ready(s_tr),
    .trace_seq(s_tseq), .trace_pc(s_tpc), .trace_instr(s_tinstr),
    .trace_rd_we(s_twe), .trace_rd_addr(s_taddr),
    .trace_rd_data(s_tdata),
    .level(s_level), .drop_count(s_drop)
  );

  commit_trace_fifo #(.STALL_ON_FULL(1'b0)) u_drop (
    .clk(clk), .rst(rst),
    .commit_valid(d_cv), .commit_ready(d_cr),
    .commit_pc(d_pc), .commit_instr(d_instr),
    .rd_we(d_we), .rd_addr(d_addr), .rd_data(d_data),
    .trace_valid(d_tv), .trace_ready(d_tr),
    .trace_seq(d_tseq), .trace_pc(d_tpc), .trace_instr(d_tinstr),
    .trace_rd_we(d_twe), .trace_rd_addr(d_taddr),
    .trace_rd_data(d_tdata),
    .level(d_level), .drop_count(d_drop)
  );

  rec_t exp_s[$];
  rec_t exp_d[$];
  int tests = 0;
  int fails = 0;
  logic [15:0] s_seq = 16'd0;
  logic [15:0] d_seq = 16'd0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic rec_t mk(input logic [15:0] sq, input logic [31:0] pc,
                              input logic [31:0] ins, input logic we,
                              input logic [3:0] a, input logic [31:0] dt);
    rec_t r;
    r.seq = sq; r.pc = pc; r.instr = ins;
    r.we = we; r.addr = a; r.data = dt;
    return r;
  endfunction

  function automatic bit same(input rec_t r, input logic [15:0] sq,
                              input logic [31:0] pc, input logic [31:0] ins,
                              input logic we, input logic [3:0] a,
                              input logic [31:0] dt);
    return (r.seq === sq) && (r.pc === pc) && (r.instr === ins) &&
           (r.we === we) && (r.addr === a) && (r.data === dt);
  endfunction

  always @(negedge clk) begin
    rec_t r;
    if (!rst && s_tv && s_tr) begin
      tests++;
      if (exp_s.size() == 0) begin
        fails++;
        $display("FAIL stall_extra: got seq %0d want none", s_tseq);
      end else begin
        r = exp_s.pop_front();
        if (!same(r, s_tseq, s_tpc, s_tinstr, s_twe, s_taddr, s_tdata)) begin
          fails++;
          $display("FAIL stall_rec: got seq %0d pc %h we %b a %0d d %h want seq %0d pc %h we %b a %0d d %h",
                   s_tseq, s_tpc, s_twe, s_taddr, s_tdata,
                   r.seq, r.pc, r.we, r.addr, r.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    rec_t r;
    if (!rst && d_tv && d_tr) begin
      tests++;
      if (exp_d.size() == 0) begin
        fails++;
        $display("FAIL drop_extra: got seq %0d want none", d_tseq);
      end else begin
        r = exp_d.pop_front();
        if (!same(r, d_tseq, d_tpc, d_tinstr, d_twe, d_taddr, d_tdata)) begin
          fails++;
          $display("FAIL drop_rec: got seq %0d pc %h we %b a %0d d %h want seq %0d pc %h we %b a %0d d %h",
                   d_tseq, d_tpc, d_twe, d_taddr, d_tdata,
                   r.seq, r.pc, r.we, r.addr, r.data);
        end
      end
    end
  end

  // Holds the commit until accepted; ewe is the hand-derived trace_rd_we.
  task automatic commit_s(input logic [31:0] pc, input logic [31:0] ins,
                          input logic we, input logic [3:0] a,
                          input logic [31:0] dt, input logic ewe);
    int n;
    s_cv = 1'b1; s_pc = pc; s_instr = ins;
    s_we = we; s_addr = a; s_data = dt;
    n = 0;
    @(negedge clk);
    while (!s_cr && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!s_cr) begin
      tests++; fails++;
      $display("FAIL stall_commit_timeout: got ready 0 want 1");
    end else begin
      exp_s.push_back(mk(s_seq, pc, ins, ewe, a, dt));
      s_seq++;
    end
    @(posedge clk); #1;
    s_cv = 1'b0;
  endtask

  // One-cycle commit; kept says whether this record should survive.
  task automatic commit_d(input bit kept, input logic [31:0] pc,
                          input logic [31:0] ins, input logic [3:0] a,
                          input logic [31:0] dt);
    d_cv = 1'b1; d_pc = pc; d_instr = ins;
    d_we = 1'b1; d_addr = a; d_data = dt;
    @(negedge clk);
    if (kept) exp_d.push_back(mk(d_seq, pc, ins, a != 0, a, dt));
    d_seq++;
    @(posedge clk); #1;
    d_cv = 1'b0;
  endtask

  task automatic drain_s(input string name);
    int n = 0;
    while ((exp_s.size() != 0 || s_tv) && n < 60) begin
      n++;
      @(posedge clk); #1;
    end
    check(name, 64'(exp_s.size()), 64'd0);
  endtask

  task automatic drain_d(input string name);
    int n = 0;
    while ((exp_d.size() != 0 || d_tv) && n < 60) begin
      n++;
      @(posedge clk); #1;
    end
    check(name, 64'(exp_d.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    exp_s.delete(); exp_d.delete();
    s_seq = 16'd0; d_seq = 16'd0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    s_cv = 0; s_pc = 0; s_instr = 0; s_we = 0; s_addr = 0; s_data = 0;
    d_cv = 0; d_pc = 0; d_instr = 0; d_we = 0; d_addr = 0; d_data = 0;
    s_tr = 1'b0; d_tr = 1'b0;

    @(posedge clk); #1;
    @(negedge clk);
    check("rst_ready_s", 64'(s_cr), 64'd0);
    check("rst_ready_d", 64'(d_cr), 64'd0);
    check("rst_level", 64'(s_level), 64'd0);
    check("rst_valid", 64'(s_tv), 64'd0);
    check("rst_drop", 64'(d_drop), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready_s", 64'(s_cr), 64'd1);
    check("post_rst_ready_d", 64'(d_cr), 64'd1);
    @(posedge clk); #1;

    // Test 1: three commits, sink always ready.
    s_tr = 1'b1;
    commit_s(32'h0, 32'h00000013, 1'b1, 4'd1, 32'h11, 1'b1);
    @(negedge clk);
    check("t1_latency", 64'(s_tv), 64'd1);
    @(posedge clk); #1;
    commit_s(32'h4, 32'h00100093, 1'b1, 4'd2, 32'h22, 1'b1);
    commit_s(32'h8, 32'h00200113, 1'b0, 4'd3, 32'h33, 1'b0);
    drain_s("t1_drained");
    @(negedge clk);
    check("t1_level", 64'(s_level), 64'd0);
    @(posedge clk); #1;

    // Test 4: x0 write is not reported, data passes through.
    commit_s(32'h100, 32'h00000033, 1'b1, 4'd0, 32'hDEADBEEF, 1'b0);
    commit_s(32'h104, 32'h00000233, 1'b1, 4'd5, 32'hCAFEF00D, 1'b1);
    drain_s("t4_drained");

    // Test 2: stall mode fill, back-pressure, then drain.
    do_reset();
    s_tr = 1'b0;
    for (int i = 0; i < 8; i++)
      commit_s(32'h1000 + 32'(4 * i), 32'h100 + 32'(i), 1'b1,
               4'(i + 1), 32'hA0 + 32'(i), 1'b1);
    @(negedge clk);
    check("t2_ready_low", 64'(s_cr), 64'd0);
    check("t2_level_full", 64'(s_level), 64'd8);
    s_cv = 1'b1; s_pc = 32'h1020; s_instr = 32'h108;
    s_we = 1'b1; s_addr = 4'd9; s_data = 32'hA8;
    @(posedge clk); #1;
    s_tr = 1'b1;
    @(negedge clk);
    check("t2_pop_no_push", 64'(s_cr), 64'd0);
    check("t2_level_hold", 64'(s_level), 64'd8);
    @(posedge clk); #1;
    @(negedge clk);
    check("t2_ready_back", 64'(s_cr), 64'd1);
    check("t2_level_7", 64'(s_level), 64'd7);
    exp_s.push_back(mk(s_seq, 32'h1020, 32'h108, 1'b1, 4'd9, 32'hA8));
    s_seq++;
    @(posedge clk); #1;
    s_cv = 1'b0;
    commit_s(32'h1024, 32'h109, 1'b1, 4'd10, 32'hA9, 1'b1);
    drain_s("t2_drained");
    check("t2_stall_drop", 64'(s_drop), 64'd0);

    // Test 3: drop mode, 11 commits into a stalled sink.
    d_tr = 1'b0;
    for (int i = 0; i < 11; i++)
      commit_d(i < 8, 32'h2000 + 32'(4 * i), 32'h200 + 32'(i),
               4'(i + 1), 32'hB0 + 32'(i));
    @(negedge clk);
    check("t3_drop_count", 64'(d_drop), 64'd3);
    check("t3_level", 64'(d_level), 64'd8);
    check("t3_ready", 64'(d_cr), 64'd1);
    @(posedge clk); #1;

    // Test 5: full with same-cycle push and pop; this record is seq 11.
    d_tr = 1'b1;
    commit_d(1'b1, 32'h2100, 32'h2FF, 4'd7, 32'hC0);
    @(negedge clk);
    check("t5_drop_same", 64'(d_drop), 64'd3);
    check("t5_level", 64'(d_level), 64'd8);
    @(posedge clk); #1;
    drain_d("t5_drained");

    // Test 6: reset with five records buffered.
    d_tr = 1'b0;
    for (int i = 0; i < 5; i++)
      commit_d(1'b1, 32'h3000 + 32'(4 * i), 32'h300 + 32'(i),
               4'(i + 1), 32'hD0 + 32'(i));
    @(negedge clk);
    check("t6_level_5", 64'(d_level), 64'd5);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_d.delete(); exp_s.delete();
    d_seq = 16'd0; s_seq = 16'd0;
    @(negedge clk);
    check("t6_ready_in_rst", 64'(d_cr), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_level", 64'(d_level), 64'd0);
    check("t6_valid", 64'(d_tv), 64'd0);
    check("t6_drop", 64'(d_drop), 64'd0);
    d_tr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("t6_still_empty", 64'(d_tv), 64'd0);
    @(posedge clk); #1;
    commit_d(1'b1, 32'h4000, 32'h400, 4'd3, 32'hE0);
    drain_d("t6_drained");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/commit_trace_fifo.md
Name: commit_trace_fifo

Overview:
- Parametrised successor to the per-cycle commit monitor. Captures one trace record per retired instruction: sequence number, PC, instruction word and register write-back.
- Records are buffered in a DEPTH-entry FIFO and drained over a valid/ready port to the simulation checker or a trace sink.
- Sits beside the core's retire stage. Decouples checker back-pressure from the pipeline, either by stalling retire or by dropping records with an accounted gap.

Parameters:
- XLEN, 32, datapath / register width.
- NREGS, 16, architectural register count; AW = $clog2(NREGS).
- DEPTH, 8, FIFO entries; power of two, >= 2.
- SEQW, 16, sequence-number width.
- CNTW, 16, drop-counter width.
- STALL_ON_FULL, 1. 1 = back-pressure retire when full; 0 = drop records when full.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- commit_valid  in  1  instruction retiring this cycle.
- commit_ready  out  1  record can be accepted.
- commit_pc  in  XLEN  PC of retiring instruction.
- commit_instr  in  32  instruction word.
- rd_we  in  1  instruction writes a register.
- rd_addr  in  AW  destination register.
- rd_data  in  XLEN  write-back value.
- trace_valid  out  1  head record available.
- trace_ready  in  1  sink accepts head record.
- trace_seq  out  SEQW  sequence number of head record.
- trace_pc  out  XLEN  head record PC.
- trace_instr  out  32  head record instruction word.
- trace_rd_we  out  1  head record write enable.
- trace_rd_addr  out  AW  head record destination.
- trace_rd_data  out  XLEN  head record write-back value.
- level  out  $clog2(DEPTH)+1  current occupancy.
- drop_count  out  CNTW  records discarded since reset.

Behaviour:
- Single clock clk; rst is synchronous, active-high, sampled on posedge clk.
- Reset values: read/write pointers 0, level 0, trace_valid 0, drop_count 0, sequence counter 0. commit_ready is 0 while rst is high and 1 on the first cycle after reset.
- Push: commit_valid && commit_ready. Pop: trace_valid && trace_ready.
- Each push writes {seq, pc, instr, rd_we', rd_addr, rd_data}. rd_we' = rd_we && (rd_addr != 0); writes to x0 are never reported.
- Sequence counter increments on every commit_valid, accepted or dropped, and wraps modulo 2^SEQW. Drops therefore appear as gaps in trace_seq.
- Latency: a record pushed into an empty FIFO gives trace_valid=1 on the next cycle. There is no combinational fall-through.
- trace_* outputs are stable while trace_valid && !trace_ready. When trace_valid=0 their values are don't-care.
- STALL_ON_FULL=1:
  - commit_ready = !full. It is registered-state only, with no combinational path from trace_ready.
  - When full, a same-cycle pop does not enable a push.
  - drop_count stays 0.
- STALL_ON_FULL=0:
  - commit_ready is constant 1 outside reset.
  - If full and no pop in the same cycle, commit_valid discards the record and drop_count increments, saturating at 2^CNTW-1.
  - If full with a same-cycle pop, the push is accepted and there is no drop.
- Simultaneous push and pop when not full: level unchanged, both pointers advance.
- Pointers carry one extra wrap bit. full = (level == DEPTH), empty = (level == 0).
- Reset asserted mid-stream flushes all entries immediately. No records are emitted afterwards until new pushes occur.

Test Plan:
1. Reset, then 3 commits PC 0x0,0x4,0x8 with trace_ready=1 -> trace_valid from cycle after first push; records seq 0,1,2 in order; level returns to 0.
2. STALL_ON_FULL=1, trace_ready=0, 10 commits -> commit_ready falls after 8th push; level=8; then trace_ready=1 -> 8 records seq 0..7 drained in order; commit_ready reasserts the cycle after first pop.
3. STALL_ON_FULL=0, trace_ready=0, 11 commits -> drop_count=3, level=8; drain yields seq 0..7; next commit gets seq 11.
4. Commit with rd_we=1, rd_addr=0, rd_data=0xDEADBEEF -> trace_rd_we=0, rd_data still 0xDEADBEEF.
5. FIFO full, STALL_ON_FULL=0, push and pop in same cycle -> drop_count unchanged, level stays 8, pushed record emitted in order.
6. rst asserted with level=5 -> next cycle level=0, trace_valid=0, drop_count=0; the next commit carries seq 0.
